// File: rtl/axi_ar_decoder_tracked_if.sv
// ---------------------------------------------------------------------------
// axi_ar_decoder_tracked_if
// Bundles the bus-facing signals of the read-address decoder:
//   - upstream AR request   : arvalid_i, araddr_i, arlen_i, arid_i -> arready_o
//   - downstream AR fan-out : arvalid_o (one-hot per initiator port), arready_i
//   - DECERR read responder : err_rvalid_o, err_rlast_o, err_rresp_o,
//                             err_rid_o, err_rready_i
// Signal suffixes are from the decoder's point of view.
// Modports:
//   slave  - the decoder itself
//   master - the surrounding fabric (or a testbench) driving the decoder
// ---------------------------------------------------------------------------
interface axi_ar_decoder_tracked_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int N_INIT_PORT = 8
) ();

    logic                   arvalid_i;
    logic [ADDR_WIDTH-1:0]  araddr_i;
    logic [7:0]             arlen_i;
    logic [ID_WIDTH-1:0]    arid_i;
    logic                   arready_o;

    logic [N_INIT_PORT-1:0] arvalid_o;
    logic [N_INIT_PORT-1:0] arready_i;

    logic                   err_rvalid_o;
    logic                   err_rlast_o;
    logic [1:0]             err_rresp_o;
    logic [ID_WIDTH-1:0]    err_rid_o;
    logic                   err_rready_i;

    modport slave (
        input  arvalid_i, araddr_i, arlen_i, arid_i, arready_i, err_rready_i,
        output arready_o, arvalid_o, err_rvalid_o, err_rlast_o, err_rresp_o, err_rid_o
    );

    modport master (
        output arvalid_i, araddr_i, arlen_i, arid_i, arready_i, err_rready_i,
        input  arready_o, arvalid_o, err_rvalid_o, err_rlast_o, err_rresp_o, err_rid_o
    );

endinterface

// File: rtl/axi_ar_decoder_tracked.sv
// ---------------------------------------------------------------------------
// axi_ar_decoder_tracked
// Read-address decoder for one target-side port of an AXI crossbar node.
// Routes each AR request to the lowest-index reachable initiator port whose
// enabled address region contains the address. Reads are tracked so that
// all outstanding reads go to a single initiator port (keeps ordering for a
// single ID). Unmapped addresses are answered by an internal DECERR
// responder producing ARLEN+1 R beats.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   bus (slave modport)  upstream AR, downstream AR fan-out, DECERR R channel
//   START_ADDR_i         region start addresses, slot j*N_INIT_PORT+i
//   END_ADDR_i           region end addresses (inclusive), same slotting
//   enable_region_i      region enables, same slotting
//   connectivity_map_i   1 = initiator port reachable from this target
//   rlast_done_i         pulse: one routed read has completed upstream
//   outstanding_o        number of routed reads accepted but not completed
// ---------------------------------------------------------------------------
module axi_ar_decoder_tracked #(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int N_INIT_PORT     = 8,
    parameter int N_REGION        = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1),
    localparam int IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    axi_ar_decoder_tracked_if.slave                 bus,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
    input  logic [N_REGION*N_INIT_PORT-1:0]         enable_region_i,
    input  logic [N_INIT_PORT-1:0]                  connectivity_map_i,
    input  logic                                    rlast_done_i,
    output logic [CNT_W-1:0]                        outstanding_o
);

    typedef enum logic {
        ROUTE,
        ERR_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    cur_tgt_q, cur_tgt_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;

    logic [N_INIT_PORT-1:0] port_hit;
    logic                   hit_any;
    logic [IDX_W-1:0]       hit_idx;
    logic                   allowed;
    logic                   route_hs;

    // Region match and priority: scanning from the top down leaves the
    // lowest-index hitting port in hit_idx.
    always_comb begin
        port_hit = '0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            for (int j = 0; j < N_REGION; j++) begin
                if (enable_region_i[j*N_INIT_PORT+i] &&
                    bus.araddr_i >= START_ADDR_i[(j*N_INIT_PORT+i)*ADDR_WIDTH +: ADDR_WIDTH] &&
                    bus.araddr_i <= END_ADDR_i[(j*N_INIT_PORT+i)*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    port_hit[i] = 1'b1;
                end
            end
        end
        port_hit = port_hit & connectivity_map_i;
        hit_any  = |port_hit;
        hit_idx  = '0;
        for (int i = N_INIT_PORT - 1; i >= 0; i--) begin
            if (port_hit[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    // A new read may only go out when nothing is in flight, or when it targets
    // the same port as the reads already in flight and there is room left.
    assign allowed = (cnt_q == '0) ||
                     (hit_idx == cur_tgt_q && cnt_q < CNT_W'(MAX_OUTSTANDING));

    // Next-state and outputs. Everything stays at zero while reset is held so
    // the downstream fabric never sees a stray request during reset.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        cur_tgt_d        = cur_tgt_q;
        beat_cnt_d       = beat_cnt_q;
        rid_d            = rid_q;
        route_hs         = 1'b0;
        bus.arready_o    = 1'b0;
        bus.arvalid_o    = '0;
        bus.err_rvalid_o = 1'b0;
        bus.err_rlast_o  = 1'b0;
        bus.err_rresp_o  = 2'b00;
        bus.err_rid_o    = '0;

        if (!rst) begin
            case (state_q)
                ROUTE: begin
                    if (hit_any) begin
                        if (allowed) begin
                            bus.arvalid_o[hit_idx] = bus.arvalid_i;
                            bus.arready_o          = bus.arready_i[hit_idx];
                            if (bus.arvalid_i && bus.arready_i[hit_idx]) begin
                                route_hs  = 1'b1;
                                cur_tgt_d = hit_idx;
                            end
                        end
                    end else if (cnt_q == '0) begin
                        // Unmapped: accept locally and answer with DECERR.
                        bus.arready_o = bus.arvalid_i;
                        if (bus.arvalid_i) begin
                            beat_cnt_d = bus.arlen_i;
                            rid_d      = bus.arid_i;
                            state_d    = ERR_RESP;
                        end
                    end
                end
                ERR_RESP: begin
                    bus.err_rvalid_o = 1'b1;
                    bus.err_rlast_o  = (beat_cnt_q == 8'd0);
                    bus.err_rresp_o  = 2'b11;
                    bus.err_rid_o    = rid_q;
                    if (bus.err_rready_i) begin
                        if (beat_cnt_q == 8'd0) begin
                            state_d = ROUTE;
                        end else begin
                            beat_cnt_d = beat_cnt_q - 8'd1;
                        end
                    end
                end
                default: state_d = ROUTE;
            endcase

            // Completion with nothing outstanding is ignored; a completion in
            // the same cycle as a new handshake cancels out.
            if (route_hs && !(rlast_done_i && cnt_q != '0)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!route_hs && rlast_done_i && cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign outstanding_o = rst ? '0 : cnt_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ROUTE;
            cnt_q      <= '0;
            cur_tgt_q  <= '0;
            beat_cnt_q <= '0;
            rid_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_tgt_q  <= cur_tgt_d;
            beat_cnt_q <= beat_cnt_d;
            rid_q      <= rid_d;
        end
    end

endmodule

// File: tb/tb_axi_ar_decoder_tracked.sv
// ---------------------------------------------------------------------------
// tb_axi_ar_decoder_tracked
// Self-checking bench for axi_ar_decoder_tracked. Directed scenarios are
// followed by a randomized phase; every cycle the outputs are compared with
// a behavioural model that tracks the outstanding count, current target
// port and remaining DECERR beats as plain integers.
// ---------------------------------------------------------------------------
module tb_axi_ar_decoder_tracked;

    localparam int AW   = 32;
    localparam int IW   = 4;
    localparam int NP   = 8;
    localparam int NR   = 4;
    localparam int MAXO = 3;
    localparam int CW   = $clog2(MAXO + 1);

    logic clk;
    logic rst;
    logic [NR*NP*AW-1:0] startVec;
    logic [NR*NP*AW-1:0] endVec;
    logic [NR*NP-1:0]    enVec;
    logic [NP-1:0]       cfgConn;
    logic                rlastDone;
    logic [CW-1:0]       outstanding;

    logic [AW-1:0] cfgStart [NR][NP];
    logic [AW-1:0] cfgEnd   [NR][NP];
    logic          cfgEn    [NR][NP];

    int checks;
    int failures;

    int mCnt;
    int mCur;
    int mErrLeft;
    int mErrRid;

    axi_ar_decoder_tracked_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .N_INIT_PORT(NP)) intf ();

    axi_ar_decoder_tracked #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .N_INIT_PORT(NP),
        .N_REGION(NR), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (intf),
        .START_ADDR_i      (startVec),
        .END_ADDR_i        (endVec),
        .enable_region_i   (enVec),
        .connectivity_map_i(cfgConn),
        .rlast_done_i      (rlastDone),
        .outstanding_o     (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flatten the region tables into the slotted vectors the decoder expects.
    always_comb begin
        startVec = '0;
        endVec   = '0;
        enVec    = '0;
        for (int j = 0; j < NR; j++) begin
            for (int i = 0; i < NP; i++) begin
                startVec[(j*NP+i)*AW +: AW] = cfgStart[j][i];
                endVec[(j*NP+i)*AW +: AW]   = cfgEnd[j][i];
                enVec[j*NP+i]               = cfgEn[j][i];
            end
        end
    end

    // Lowest reachable port owning the address, or -1 when unmapped.
    function automatic int modelTarget(input logic [AW-1:0] addr);
        for (int i = 0; i < NP; i++) begin
            if (cfgConn[i]) begin
                for (int j = 0; j < NR; j++) begin
                    if (cfgEn[j][i] && addr >= cfgStart[j][i] && addr <= cfgEnd[j][i]) begin
                        return i;
                    end
                end
            end
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] addr, input logic [7:0] len,
                                 input logic [IW-1:0] id, input logic [NP-1:0] rdy,
                                 input logic rlast, input logic errRdy, input logic r);
        intf.arvalid_i    = v;
        intf.araddr_i     = addr;
        intf.arlen_i      = len;
        intf.arid_i       = id;
        intf.arready_i    = rdy;
        intf.err_rready_i = errRdy;
        rlastDone         = rlast;
        rst               = r;
        #1;
    endtask

    // Compare every output against the model, clock once, advance the model.
    task automatic runCycle();
        int tgt;
        bit allowed;
        int inc;
        int dec;
        logic [NP-1:0] expArv;
        logic expArr, expEv, expEl;
        logic [1:0] expResp;
        logic [IW-1:0] expRid;
        tgt = modelTarget(intf.araddr_i);
        allowed = (mCnt == 0) || (tgt == mCur && mCnt < MAXO);
        expArv = '0; expArr = 1'b0; expEv = 1'b0; expEl = 1'b0; expResp = 2'b00; expRid = '0;
        if (!rst) begin
            if (mErrLeft > 0) begin
                expEv = 1'b1; expEl = (mErrLeft == 1); expResp = 2'b11; expRid = IW'(mErrRid);
            end else if (tgt >= 0) begin
                if (allowed && intf.arvalid_i) expArv = NP'(1) << tgt;
                expArr = allowed && intf.arready_i[tgt];
            end else begin
                expArr = intf.arvalid_i && (mCnt == 0);
            end
        end
        checkOutput("arvalid_o", 32'(intf.arvalid_o), 32'(expArv));
        checkOutput("arready_o", 32'(intf.arready_o), 32'(expArr));
        checkOutput("err_rvalid", 32'(intf.err_rvalid_o), 32'(expEv));
        checkOutput("err_rlast", 32'(intf.err_rlast_o), 32'(expEl));
        checkOutput("err_rresp", 32'(intf.err_rresp_o), 32'(expResp));
        checkOutput("err_rid", 32'(intf.err_rid_o), 32'(expRid));
        checkOutput("outstanding", 32'(outstanding), rst ? 32'd0 : 32'(mCnt));
        @(posedge clk);
        if (rst) begin
            mCnt = 0; mCur = 0; mErrLeft = 0; mErrRid = 0;
        end else begin
            inc = 0;
            if (mErrLeft > 0) begin
                if (intf.err_rready_i) mErrLeft--;
            end else if (tgt >= 0) begin
                if (allowed && intf.arvalid_i && intf.arready_i[tgt]) begin
                    inc = 1; mCur = tgt;
                end
            end else if (intf.arvalid_i && mCnt == 0) begin
                mErrLeft = int'(intf.arlen_i) + 1;
                mErrRid  = int'(intf.arid_i);
            end
            dec = (rlastDone && mCnt > 0) ? 1 : 0;
            mCnt = mCnt + inc - dec;
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        mCnt = 0; mCur = 0; mErrLeft = 0; mErrRid = 0;
        for (int j = 0; j < NR; j++) begin
            for (int i = 0; i < NP; i++) begin
                cfgStart[j][i] = '0; cfgEnd[j][i] = '0; cfgEn[j][i] = 1'b0;
            end
        end
        cfgConn = 8'hFF;
        cfgStart[0][2] = 32'h1000; cfgEnd[0][2] = 32'h1FFF; cfgEn[0][2] = 1'b1;
        cfgStart[0][5] = 32'h5000; cfgEnd[0][5] = 32'h5FFF; cfgEn[0][5] = 1'b1;

        // Reset
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1);
        @(negedge clk);
        runCycle(); runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        runCycle();

        // Single routed read to port 2
        applyStimulus(1, 32'h1800, 0, 1, 8'h04, 0, 0, 0);
        checkOutput("t1_arvalid", 32'(intf.arvalid_o), 32'h04);
        checkOutput("t1_arready", 32'(intf.arready_o), 32'd1);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 0);
        checkOutput("t1_outstanding", 32'(outstanding), 32'd1);
        runCycle();

        // Priority between overlapping ports, then connectivity masking
        cfgEn[0][2] = 1'b0;
        cfgStart[1][1] = 32'h1800; cfgEnd[1][1] = 32'h18FF; cfgEn[1][1] = 1'b1;
        cfgStart[2][3] = 32'h1000; cfgEnd[2][3] = 32'h2FFF; cfgEn[2][3] = 1'b1;
        applyStimulus(1, 32'h1800, 0, 2, 8'h00, 0, 0, 0);
        checkOutput("t2_prio", 32'(intf.arvalid_o), 32'h02);
        runCycle();
        cfgConn = 8'hFD;
        applyStimulus(1, 32'h1800, 0, 2, 8'h00, 0, 0, 0);
        checkOutput("t2_conn", 32'(intf.arvalid_o), 32'h08);
        runCycle();
        cfgConn = 8'hFF; cfgEn[0][2] = 1'b1; cfgEn[1][1] = 1'b0; cfgEn[2][3] = 1'b0;

        // Different-port request stalls until the first read drains
        applyStimulus(1, 32'h1800, 0, 1, 8'h04, 0, 0, 0);
        runCycle();
        applyStimulus(1, 32'h5800, 0, 1, 8'h20, 0, 0, 0);
        checkOutput("t3_stall", 32'(intf.arvalid_o), 32'h00);
        runCycle();
        applyStimulus(1, 32'h5800, 0, 1, 8'h20, 1, 0, 0);
        runCycle();
        applyStimulus(1, 32'h5800, 0, 1, 8'h20, 0, 0, 0);
        checkOutput("t3_fwd", 32'(intf.arvalid_o), 32'h20);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 0);
        runCycle();

        // DECERR burst with back-pressure
        applyStimulus(1, 32'hF000, 3, 5, 8'h00, 0, 0, 0);
        checkOutput("t4_accept", 32'(intf.arready_o), 32'd1);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 0);
        checkOutput("t4_rid", 32'(intf.err_rid_o), 32'd5);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0);
        runCycle(); runCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 0);
            checkOutput("t4_rlast", 32'(intf.err_rlast_o), (k == 2) ? 32'd1 : 32'd0);
            runCycle();
        end
        checkOutput("t4_done", 32'(intf.err_rvalid_o), 32'd0);

        // Outstanding limit and simultaneous handshake + completion
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 32'h1234, 0, 3, 8'h04, 0, 0, 0);
            runCycle();
        end
        checkOutput("t5_full", 32'(outstanding), 32'(MAXO));
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 0);
        runCycle(); runCycle();
        applyStimulus(1, 32'h1234, 0, 3, 8'h04, 1, 0, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("t5_same", 32'(outstanding), 32'd1);
        runCycle();

        // Reset with reads outstanding, then reset in mid DECERR burst
        applyStimulus(1, 32'h1234, 0, 3, 8'h04, 0, 0, 0);
        runCycle(); runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0);
        checkOutput("t6_cnt_rst", 32'(outstanding), 32'd0);
        applyStimulus(1, 32'hF000, 3, 9, 8'h00, 0, 1, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 1);
        runCycle();
        applyStimulus(1, 32'h1800, 0, 1, 8'h04, 0, 0, 0);
        checkOutput("t6_err_rst", 32'(intf.err_rvalid_o), 32'd0);
        checkOutput("t6_route", 32'(intf.arvalid_o), 32'h04);
        runCycle();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [AW-1:0] addr;
            case ($urandom_range(0, 6))
                0: addr = 32'h1800;
                1: addr = 32'h5800;
                2: addr = 32'h1000;
                3: addr = 32'h5FFF;
                4: addr = 32'hF000;
                5: addr = 32'h0000_0FFF;
                default: addr = 32'h1FFF;
            endcase
            if (k % 64 == 63) cfgConn = 8'hFF ^ (8'h1 << $urandom_range(0, 7));
            applyStimulus($urandom_range(0, 3) != 0, addr, 8'($urandom_range(0, 3)),
                          IW'($urandom), NP'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
            runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
